// File: rtl/mesh_pkg.sv
// rtl/mesh_pkg.sv - shared encodings and helpers for the ADPLL mesh sequencer
package mesh_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CONFIG = 3'd1,
        ST_RAMP   = 3'd2,
        ST_LOCKED = 3'd3,
        ST_FAULT  = 3'd4
    } state_e;

    localparam logic [1:0] MODE_PLL = 2'b00;
    localparam logic [1:0] MODE_UNI = 2'b01;
    localparam logic [1:0] MODE_BI  = 2'b10;

    localparam logic [1:0] REF_EXT  = 2'd0;
    localparam logic [1:0] REF_NBR  = 2'd1;
    localparam logic [1:0] REF_LOOP = 2'd2;

    // Field index inside a node's {left,above,right,below} weight word
    localparam int W_LEFT  = 3;
    localparam int W_ABOVE = 2;
    localparam int W_RIGHT = 1;
    localparam int W_BELOW = 0;

    // Bits needed to hold the values 0 .. value-1 (at least one bit)
    function automatic int clog2(input int value);
        int bits;
        bits = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << bits) < value) begin
                bits = i + 1;
            end
        end
        return bits;
    endfunction

    // Code 11 is reserved and behaves like the plain PLL mode
    function automatic logic is_pll(input logic [1:0] mode);
        return !((mode == MODE_UNI) || (mode == MODE_BI));
    endfunction

endpackage

// File: rtl/node_lock_det.sv
// rtl/node_lock_det.sv - per-node consecutive in-threshold lock counter
module node_lock_det
    import mesh_pkg::*;
#(
    parameter int PDET_WIDTH  = 5,
    parameter int LOCK_THRESH = 2,
    parameter int LOCK_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  run_i,
    input  logic [PDET_WIDTH-1:0] error_mag_i,
    output logic                  locked_o
);

    localparam int               CNT_W   = clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             locked_q, locked_d;

    // Count consecutive good samples; any bad or idle sample restarts the run
    always_comb begin
        cnt_d = '0;
        if (run_i && (error_mag_i <= PDET_WIDTH'(LOCK_THRESH))) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
        locked_d = (cnt_d == CNT_MAX);
    end

    // Counter and lock flag registers
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
        end
    end

    assign locked_o = locked_q;

endmodule

// File: rtl/adpll_mesh_seq.sv
// rtl/adpll_mesh_seq.sv - ROWSxCOLS ADPLL mesh bring-up sequencer with weights and gains
module adpll_mesh_seq
    import mesh_pkg::*;
#(
    parameter int ROWS           = 2,
    parameter int COLS           = 2,
    parameter int PDET_WIDTH     = 5,
    parameter int WEIGHT_WIDTH   = 4,
    parameter int GAIN_WIDTH     = 4,
    parameter int LOCK_THRESH    = 2,
    parameter int LOCK_CYCLES    = 1024,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                                 fpga_clk_i,
    input  logic                                 rst_n_i,
    input  logic                                 enable_i,
    input  logic [1:0]                           mode_i,
    input  logic                                 load_gains_i,
    input  logic [GAIN_WIDTH-1:0]                kp_i,
    input  logic [GAIN_WIDTH-1:0]                ki_i,
    input  logic [ROWS*COLS*PDET_WIDTH-1:0]      error_mag_i,
    output logic [ROWS*COLS-1:0]                 node_en_o,
    output logic [ROWS*COLS*4*WEIGHT_WIDTH-1:0]  weight_o,
    output logic [ROWS*COLS*4-1:0]               ref_sel_o,
    output logic [GAIN_WIDTH-1:0]                kp_o,
    output logic [GAIN_WIDTH-1:0]                ki_o,
    output logic [ROWS*COLS-1:0]                 locked_o,
    output logic                                 all_locked_o,
    output logic                                 fault_o,
    output logic [2:0]                           state_o
);

    localparam int NODES  = ROWS * COLS;
    localparam int NW     = 4 * WEIGHT_WIDTH;
    localparam int LAST_D = ROWS + COLS - 2;
    localparam int D_W    = clog2(LAST_D + 1);
    localparam int TMO_W  = clog2(TIMEOUT_CYCLES + 1);

    state_e                  state_q, state_d;
    logic [1:0]              mode_q, mode_d;
    logic [D_W-1:0]          d_q, d_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic [NODES*NW-1:0]     weight_q, weight_d, weight_cfg;
    logic [NODES*4-1:0]      ref_sel_q, ref_sel_d, ref_sel_cfg;
    logic [GAIN_WIDTH-1:0]   kp_q, kp_d, ki_q, ki_d;
    logic [NODES-1:0]        node_en, front, locked;
    logic                    pll_q;

    assign pll_q = is_pll(mode_q);

    // Weight and reference-select tables for the mode presented during CONFIG
    always_comb begin
        int n, n_up, n_dn, up_w, dn_w;
        logic left_up, above_up;
        weight_cfg  = '0;
        ref_sel_cfg = '0;
        n = 0; n_up = 1; n_dn = 0; up_w = 0; dn_w = 0;
        left_up = 1'b0; above_up = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                n        = r * COLS + c;
                left_up  = (r == 0) || (c > 0);
                above_up = (r > 0);
                n_up     = (left_up ? 1 : 0) + (above_up ? 1 : 0);
                n_dn     = ((c < COLS - 1) ? 1 : 0) + ((r < ROWS - 1) ? 1 : 0);
                if (is_pll(mode_i)) begin
                    weight_cfg[n*NW + W_LEFT*WEIGHT_WIDTH +: WEIGHT_WIDTH] = WEIGHT_WIDTH'(4);
                end else begin
                    // Bi-directional splits 2/2 unless the node has nobody downstream
                    if ((mode_i == MODE_BI) && (n_dn > 0)) begin
                        up_w = 2 / n_up;
                        dn_w = 2 / n_dn;
                    end else begin
                        up_w = 4 / n_up;
                        dn_w = 0;
                    end
                    if (left_up) begin
                        weight_cfg[n*NW + W_LEFT*WEIGHT_WIDTH +: WEIGHT_WIDTH] = WEIGHT_WIDTH'(up_w);
                    end
                    if (above_up) begin
                        weight_cfg[n*NW + W_ABOVE*WEIGHT_WIDTH +: WEIGHT_WIDTH] = WEIGHT_WIDTH'(up_w);
                    end
                    if (c < COLS - 1) begin
                        weight_cfg[n*NW + W_RIGHT*WEIGHT_WIDTH +: WEIGHT_WIDTH] = WEIGHT_WIDTH'(dn_w);
                    end
                    if (r < ROWS - 1) begin
                        weight_cfg[n*NW + W_BELOW*WEIGHT_WIDTH +: WEIGHT_WIDTH] = WEIGHT_WIDTH'(dn_w);
                    end
                    if (r == 0 && c == 0) begin
                        ref_sel_cfg[n*4 +: 4] = {REF_EXT, REF_LOOP};
                    end else if (r == 0) begin
                        ref_sel_cfg[n*4 +: 4] = {REF_NBR, REF_LOOP};
                    end else if (c == 0) begin
                        ref_sel_cfg[n*4 +: 4] = {REF_LOOP, REF_NBR};
                    end else begin
                        ref_sel_cfg[n*4 +: 4] = {REF_NBR, REF_NBR};
                    end
                end
            end
        end
    end

    // Enabled region (anti-diagonals up to d) and the wavefront currently being locked
    always_comb begin
        node_en = '0;
        front   = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                front[r*COLS+c] = pll_q || ((r + c) == int'(d_q));
                if ((state_q == ST_RAMP) || (state_q == ST_LOCKED) || (state_q == ST_FAULT)) begin
                    node_en[r*COLS+c] = pll_q || ((r + c) <= int'(d_q));
                end
            end
        end
    end

    // Sequencer next state: config latch, wavefront advance, timeout
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        d_d       = d_q;
        tmo_d     = tmo_q;
        weight_d  = weight_q;
        ref_sel_d = ref_sel_q;
        if (!enable_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_CONFIG;
                ST_CONFIG: begin
                    mode_d    = mode_i;
                    weight_d  = weight_cfg;
                    ref_sel_d = ref_sel_cfg;
                    d_d       = '0;
                    tmo_d     = '0;
                    state_d   = ST_RAMP;
                end
                ST_RAMP: begin
                    if (&(locked | ~front)) begin
                        if (pll_q || (int'(d_q) == LAST_D)) begin
                            state_d = ST_LOCKED;
                        end else begin
                            d_d   = d_q + 1'b1;
                            tmo_d = '0;
                        end
                    end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d = ST_FAULT;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                ST_LOCKED: state_d = ST_LOCKED;
                ST_FAULT:  state_d = ST_FAULT;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Gain register loads whenever the pulse is seen
    always_comb begin
        kp_d = load_gains_i ? kp_i : kp_q;
        ki_d = load_gains_i ? ki_i : ki_q;
    end

    // Sequencer, configuration and gain registers
    always_ff @(posedge fpga_clk_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_PLL;
            d_q       <= '0;
            tmo_q     <= '0;
            weight_q  <= '0;
            ref_sel_q <= '0;
            kp_q      <= GAIN_WIDTH'(1);
            ki_q      <= GAIN_WIDTH'(1);
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            d_q       <= d_d;
            tmo_q     <= tmo_d;
            weight_q  <= weight_d;
            ref_sel_q <= ref_sel_d;
            kp_q      <= kp_d;
            ki_q      <= ki_d;
        end
    end

    for (genvar g = 0; g < NODES; g++) begin : g_lock
        node_lock_det #(
            .PDET_WIDTH  (PDET_WIDTH),
            .LOCK_THRESH (LOCK_THRESH),
            .LOCK_CYCLES (LOCK_CYCLES)
        ) u_lock (
            .clk_i       (fpga_clk_i),
            .rst_n_i     (rst_n_i),
            .run_i       (node_en[g] & enable_i),
            .error_mag_i (error_mag_i[g*PDET_WIDTH +: PDET_WIDTH]),
            .locked_o    (locked[g])
        );
    end

    assign node_en_o    = node_en;
    assign weight_o     = weight_q;
    assign ref_sel_o    = ref_sel_q;
    assign kp_o         = kp_q;
    assign ki_o         = ki_q;
    assign locked_o     = locked;
    assign all_locked_o = (state_q == ST_LOCKED) && (&locked);
    assign fault_o      = (state_q == ST_FAULT);
    assign state_o      = state_q;

endmodule

// File: tb/tb_adpll_mesh_seq.sv
// tb/tb_adpll_mesh_seq.sv - self-checking bench for the 2x2 ADPLL mesh sequencer
module tb_adpll_mesh_seq;

    localparam int ROWS = 2, COLS = 2, NODES = 4, PW = 5, WW = 4, GW = 4;
    localparam int LOCKN = 16, TMO = 100;

    logic                   clk = 1'b0;
    logic                   rst_n, enable, load_gains;
    logic [1:0]             mode;
    logic [GW-1:0]          kp, ki;
    logic [NODES*PW-1:0]    err;
    logic [NODES-1:0]       node_en_o, locked_o;
    logic [NODES*4*WW-1:0]  weight_o;
    logic [NODES*4-1:0]     ref_sel_o;
    logic [GW-1:0]          kp_o, ki_o;
    logic                   all_locked_o, fault_o;
    logic [2:0]             state_o;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    adpll_mesh_seq #(
        .ROWS(ROWS), .COLS(COLS), .PDET_WIDTH(PW), .WEIGHT_WIDTH(WW), .GAIN_WIDTH(GW),
        .LOCK_THRESH(2), .LOCK_CYCLES(LOCKN), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .fpga_clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .mode_i(mode),
        .load_gains_i(load_gains), .kp_i(kp), .ki_i(ki), .error_mag_i(err),
        .node_en_o(node_en_o), .weight_o(weight_o), .ref_sel_o(ref_sel_o),
        .kp_o(kp_o), .ki_o(ki_o), .locked_o(locked_o), .all_locked_o(all_locked_o),
        .fault_o(fault_o), .state_o(state_o)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [63:0] w;
        logic [15:0] rs;
        logic [3:0]  en;
    } vec_t;

    vec_t        tbl[4];
    logic [63:0] w_by_mode[4];
    logic [15:0] rs_by_mode[4];

    // Reference model state
    int          m_state, m_d, m_tmo, m_mode, rate;
    logic [15:0] m_hist[NODES];
    logic [63:0] m_w;
    logic [15:0] m_rs;
    logic [GW-1:0] m_kp, m_ki;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit m_pll();
        return !(m_mode == 1 || m_mode == 2);
    endfunction

    function automatic logic [3:0] m_en();
        logic [3:0] e;
        e = '0;
        for (int n = 0; n < NODES; n++) begin
            if (m_state >= 2 && (m_pll() || (n / COLS + n % COLS) <= m_d)) e[n] = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [3:0] m_locked();
        logic [3:0] l;
        for (int n = 0; n < NODES; n++) l[n] = &m_hist[n];
        return l;
    endfunction

    task automatic model_reset();
        m_state = 0; m_d = 0; m_tmo = 0; m_mode = 0;
        m_w = '0; m_rs = '0; m_kp = 4'd1; m_ki = 4'd1;
        for (int n = 0; n < NODES; n++) m_hist[n] = '0;
    endtask

    // One clock of the model: lock = last LOCKN samples all good while enabled
    task automatic model_step();
        logic [3:0] en, lk;
        bit all_front;
        en = m_en();
        lk = m_locked();
        for (int n = 0; n < NODES; n++) begin
            m_hist[n] = {m_hist[n][14:0], en[n] && enable && (err[n*PW +: PW] <= 2)};
        end
        if (load_gains) begin
            m_kp = kp;
            m_ki = ki;
        end
        if (!enable) begin
            m_state = 0;
        end else if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 1) begin
            m_mode = mode; m_w = w_by_mode[mode]; m_rs = rs_by_mode[mode];
            m_d = 0; m_tmo = 0; m_state = 2;
        end else if (m_state == 2) begin
            all_front = 1;
            for (int n = 0; n < NODES; n++) begin
                if ((m_pll() || (n / COLS + n % COLS) == m_d) && !lk[n]) all_front = 0;
            end
            if (all_front) begin
                if (m_pll() || m_d == ROWS + COLS - 2) m_state = 3;
                else begin
                    m_d++;
                    m_tmo = 0;
                end
            end else begin
                m_tmo++;
                if (m_tmo >= TMO) m_state = 4;
            end
        end
    endtask

    initial begin
        int cnt;
        logic [3:0] lk;

        w_by_mode[0]  = 64'h4000_4000_4000_4000;
        w_by_mode[1]  = 64'h2200_0400_4000_4000;
        w_by_mode[2]  = 64'h2200_0220_2002_2011;
        w_by_mode[3]  = 64'h4000_4000_4000_4000;
        rs_by_mode[0] = 16'h0000;
        rs_by_mode[1] = 16'h5962;
        rs_by_mode[2] = 16'h5962;
        rs_by_mode[3] = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            tbl[i] = '{mode: 2'(i), w: w_by_mode[i], rs: rs_by_mode[i],
                       en: (i == 1 || i == 2) ? 4'b0001 : 4'b1111};
        end

        // Reset with a coincident gain load: reset must win
        rst_n = 0; enable = 0; load_gains = 1; kp = 4'd9; ki = 4'd9; mode = 0; err = '0;
        tick(); tick();
        chk("rst_state", state_o, 0);
        chk("rst_node_en", node_en_o, 0);
        chk("rst_weight", weight_o, 0);
        chk("rst_ref_sel", ref_sel_o, 0);
        chk("rst_locked", locked_o, 0);
        chk("rst_all_locked", all_locked_o, 0);
        chk("rst_fault", fault_o, 0);
        chk("rst_kp", kp_o, 1);
        chk("rst_ki", ki_o, 1);
        load_gains = 0; rst_n = 1;
        tick();

        // Table-driven: tables and enables in the first RAMP cycle per mode
        for (int i = 0; i < 4; i++) begin
            enable = 0; tick();
            mode = tbl[i].mode; enable = 1;
            tick(); tick();
            chk("tbl_state", state_o, 2);
            chk("tbl_weight", weight_o, tbl[i].w);
            chk("tbl_ref_sel", ref_sel_o, tbl[i].rs);
            chk("tbl_node_en", node_en_o, tbl[i].en);
        end

        // Uni-directional wavefront ramp with clean errors
        enable = 0; tick();
        mode = 2'b01; enable = 1; tick(); tick();
        chk("uni_en0", node_en_o, 4'b0001);
        cnt = 0;
        while (node_en_o != 4'b0111 && cnt < 200) begin tick(); cnt++; end
        chk("uni_step1_cycles", cnt, LOCKN + 1);
        cnt = 0;
        while (node_en_o != 4'b1111 && cnt < 200) begin tick(); cnt++; end
        chk("uni_step2_cycles", cnt, LOCKN + 1);
        cnt = 0;
        while (state_o != 3 && cnt < 200) begin tick(); cnt++; end
        chk("uni_locked_cycles", cnt, LOCKN + 1);
        chk("uni_all_locked", all_locked_o, 1);

        // One-cycle glitch on node 2 while LOCKED
        err[2*PW +: PW] = 5'd5; tick();
        err = '0;
        chk("glitch_locked", locked_o, 4'b1011);
        chk("glitch_all_locked", all_locked_o, 0);
        chk("glitch_state", state_o, 3);
        cnt = 0;
        while (locked_o != 4'b1111 && cnt < 200) begin tick(); cnt++; end
        chk("relock_cycles", cnt, LOCKN);
        chk("relock_all_locked", all_locked_o, 1);

        // Wavefront timeout on node (1,1)
        enable = 0; tick();
        err[3*PW +: PW] = 5'd10; mode = 2'b01; enable = 1; tick(); tick();
        cnt = 0;
        while (node_en_o != 4'b1111 && cnt < 200) begin tick(); cnt++; end
        chk("tmo_front2_reached", cnt < 200, 1);
        cnt = 0;
        while (state_o != 4 && cnt < 300) begin tick(); cnt++; end
        chk("tmo_cycles", cnt, TMO);
        chk("tmo_fault", fault_o, 1);
        chk("tmo_node_en", node_en_o, 4'b1111);
        enable = 0; tick();
        chk("tmo_clear_fault", fault_o, 0);
        chk("tmo_clear_state", state_o, 0);
        err = '0;

        // Mode change during RAMP ignored, gain load, enable drop
        mode = 2'b10; enable = 1; tick(); tick();
        mode = 2'b00; tick(); tick(); tick();
        chk("ramp_mode_weight", weight_o, w_by_mode[2]);
        chk("ramp_mode_en", node_en_o, 4'b0001);
        load_gains = 1; kp = 4'd6; ki = 4'd3; tick();
        load_gains = 0;
        chk("gain_kp", kp_o, 6);
        chk("gain_ki", ki_o, 3);
        enable = 0; tick();
        chk("drop_state", state_o, 0);
        chk("drop_node_en", node_en_o, 0);
        chk("drop_weight_kept", weight_o, w_by_mode[2]);
        chk("drop_kp_kept", kp_o, 6);

        // Randomized run against the reference model
        rst_n = 0; tick();
        rst_n = 1;
        model_reset();
        rate = 2;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (m_state == 0) enable = ($urandom % 4) != 0;
            else enable = ($urandom % 400) != 0;
            if (m_state == 1) begin
                case ($urandom % 3)
                    0: rate = 0;
                    1: rate = 2;
                    default: rate = 30;
                endcase
            end
            mode = 2'($urandom % 4);
            load_gains = ($urandom % 20) == 0;
            kp = 4'($urandom); ki = 4'($urandom);
            for (int n = 0; n < NODES; n++) begin
                if (int'($urandom % 100) < rate) err[n*PW +: PW] = 5'($urandom_range(3, 31));
                else err[n*PW +: PW] = 5'($urandom_range(0, 2));
            end
            model_step();
            tick();
            lk = m_locked();
            chk("rnd_state", state_o, m_state);
            chk("rnd_node_en", node_en_o, m_en());
            chk("rnd_locked", locked_o, lk);
            chk("rnd_all_locked", all_locked_o, (m_state == 3) && (&lk));
            chk("rnd_fault", fault_o, m_state == 4);
            chk("rnd_kp", kp_o, m_kp);
            chk("rnd_ki", ki_o, m_ki);
            chk("rnd_weight", weight_o, m_w);
            chk("rnd_ref_sel", ref_sel_o, m_rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
